// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IF/LSU memory arbiter: FSM states and byte-enable patterns.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_WAIT  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_ERR  = 2'd3
  } arb_state_e;

  localparam logic [3:0] BE_WORD    = 4'hF;
  localparam logic [3:0] BE_HALF_LO = 4'h3;
  localparam logic [3:0] BE_HALF_HI = 4'hC;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of fetch losses; at_max tells the arbiter to let the fetch through.
module arb_starve_ctr #(
  parameter int MAX = 3
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [3:0] cnt;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != 4'(MAX))) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign at_max = (cnt == 4'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// with one outstanding transaction and local rejection of misaligned LSU accesses.
module mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk_in,
  input  logic            reset_n,
  input  logic            if_req_in,
  input  logic [XLEN-1:0] if_addr_in,
  output logic            if_gnt_out,
  output logic            if_rvalid_out,
  output logic [XLEN-1:0] if_rdata_out,
  input  logic            lsu_req_in,
  input  logic            lsu_we_in,
  input  logic [3:0]      lsu_be_in,
  input  logic [XLEN-1:0] lsu_addr_in,
  input  logic [XLEN-1:0] lsu_wdata_in,
  output logic            lsu_gnt_out,
  output logic            lsu_rvalid_out,
  output logic [XLEN-1:0] lsu_rdata_out,
  output logic            lsu_err_out,
  output logic            mem_req_out,
  output logic            mem_we_out,
  output logic [3:0]      mem_be_out,
  output logic [XLEN-1:0] mem_addr_out,
  output logic [XLEN-1:0] mem_wdata_out,
  input  logic            mem_gnt_in,
  input  logic            mem_rvalid_in,
  input  logic [XLEN-1:0] mem_rdata_in
);
  import mem_arbiter_pkg::*;

  arb_state_e state, state_nxt;
  logic       lsu_store_q;
  logic       starve_max, starve_inc, starve_clr;
  logic       lsu_win, if_win, lsu_bad;

  // Byte enables must describe a naturally aligned byte, half or word at addr[1:0].
  function automatic logic misaligned(input logic [3:0] be, input logic [1:0] off);
    case (be)
      4'h1:       misaligned = (off != 2'd0);
      4'h2:       misaligned = (off != 2'd1);
      4'h4:       misaligned = (off != 2'd2);
      4'h8:       misaligned = (off != 2'd3);
      BE_HALF_LO: misaligned = (off != 2'd0);
      BE_HALF_HI: misaligned = (off != 2'd2);
      BE_WORD:    misaligned = (off != 2'd0);
      default:    misaligned = 1'b1;
    endcase
  endfunction

  arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (starve_max)
  );

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      lsu_store_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && lsu_gnt_out) begin
        lsu_store_q <= lsu_we_in;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    if_gnt_out     = 1'b0;
    if_rvalid_out  = 1'b0;
    if_rdata_out   = '0;
    lsu_gnt_out    = 1'b0;
    lsu_rvalid_out = 1'b0;
    lsu_rdata_out  = '0;
    lsu_err_out    = 1'b0;
    mem_req_out    = 1'b0;
    mem_we_out     = 1'b0;
    mem_be_out     = '0;
    mem_addr_out   = '0;
    mem_wdata_out  = '0;
    starve_inc     = 1'b0;
    starve_clr     = 1'b0;
    lsu_win        = lsu_req_in && !(if_req_in && starve_max);
    if_win         = if_req_in && !lsu_win;
    lsu_bad        = misaligned(lsu_be_in, lsu_addr_in[1:0]);

    case (state)
      IDLE: begin
        // Gated by reset_n so every output reads 0 while reset is held.
        if (reset_n) begin
          if (lsu_win) begin
            starve_inc = if_req_in && (lsu_bad || mem_gnt_in);
            if (lsu_bad) begin
              lsu_gnt_out = 1'b1;
              state_nxt   = LSU_ERR;
            end else begin
              mem_req_out   = 1'b1;
              mem_we_out    = lsu_we_in;
              mem_be_out    = lsu_be_in;
              mem_addr_out  = lsu_addr_in;
              mem_wdata_out = lsu_wdata_in;
              lsu_gnt_out   = mem_gnt_in;
              if (mem_gnt_in) state_nxt = LSU_WAIT;
            end
          end else if (if_win) begin
            mem_req_out  = 1'b1;
            mem_be_out   = BE_WORD;
            mem_addr_out = if_addr_in;
            if_gnt_out   = mem_gnt_in;
            if (mem_gnt_in) begin
              starve_clr = 1'b1;
              state_nxt  = IF_WAIT;
            end
          end
        end
      end
      IF_WAIT: begin
        if (mem_rvalid_in) begin
          if_rvalid_out = 1'b1;
          if_rdata_out  = mem_rdata_in;
          state_nxt     = IDLE;
        end
      end
      LSU_WAIT: begin
        if (mem_rvalid_in) begin
          lsu_rvalid_out = 1'b1;
          lsu_rdata_out  = lsu_store_q ? '0 : mem_rdata_in;
          state_nxt      = IDLE;
        end
      end
      LSU_ERR: begin
        lsu_rvalid_out = 1'b1;
        lsu_err_out    = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, reset sequences and
// randomized traffic compared against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 3;
  localparam int OWN_NONE = 0, OWN_IF = 1, OWN_LSU = 2, OWN_ERR = 3;

  logic            clk_in = 1'b0;
  logic            reset_n;
  logic            if_req_in, lsu_req_in, lsu_we_in, mem_gnt_in, mem_rvalid_in;
  logic [XLEN-1:0] if_addr_in, lsu_addr_in, lsu_wdata_in, mem_rdata_in;
  logic [3:0]      lsu_be_in;
  logic            if_gnt_out, if_rvalid_out, lsu_gnt_out, lsu_rvalid_out, lsu_err_out;
  logic            mem_req_out, mem_we_out;
  logic [XLEN-1:0] if_rdata_out, lsu_rdata_out, mem_addr_out, mem_wdata_out;
  logic [3:0]      mem_be_out;

  always #5 clk_in = ~clk_in;

  mem_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_in        (clk_in),
    .reset_n       (reset_n),
    .if_req_in     (if_req_in),
    .if_addr_in    (if_addr_in),
    .if_gnt_out    (if_gnt_out),
    .if_rvalid_out (if_rvalid_out),
    .if_rdata_out  (if_rdata_out),
    .lsu_req_in    (lsu_req_in),
    .lsu_we_in     (lsu_we_in),
    .lsu_be_in     (lsu_be_in),
    .lsu_addr_in   (lsu_addr_in),
    .lsu_wdata_in  (lsu_wdata_in),
    .lsu_gnt_out   (lsu_gnt_out),
    .lsu_rvalid_out(lsu_rvalid_out),
    .lsu_rdata_out (lsu_rdata_out),
    .lsu_err_out   (lsu_err_out),
    .mem_req_out   (mem_req_out),
    .mem_we_out    (mem_we_out),
    .mem_be_out    (mem_be_out),
    .mem_addr_out  (mem_addr_out),
    .mem_wdata_out (mem_wdata_out),
    .mem_gnt_in    (mem_gnt_in),
    .mem_rvalid_in (mem_rvalid_in),
    .mem_rdata_in  (mem_rdata_in)
  );

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        lsu_req;
    logic        lsu_we;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        lsu_gnt;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   m_owner, m_starve, n_owner, n_starve;
  bit   m_store, n_store;
  vec_t tbl[$];
  logic [3:0] be_pool [0:11];

  function automatic in_t mk_in(logic ir, logic [31:0] ia, logic lr, logic lw, logic [3:0] lb,
                                logic [31:0] la, logic [31:0] ld, logic g, logic rv,
                                logic [31:0] rd);
    in_t s;
    s.if_req = ir; s.if_addr = ia; s.lsu_req = lr; s.lsu_we = lw; s.lsu_be = lb;
    s.lsu_addr = la; s.lsu_wdata = ld; s.mem_gnt = g; s.mem_rvalid = rv; s.mem_rdata = rd;
    return s;
  endfunction

  function automatic out_t mk_out(logic ig, logic irv, logic [31:0] ird, logic lg, logic lrv,
                                  logic [31:0] lrd, logic le, logic mr, logic mw,
                                  logic [3:0] mb, logic [31:0] ma, logic [31:0] md);
    out_t o;
    o.if_gnt = ig; o.if_rvalid = irv; o.if_rdata = ird; o.lsu_gnt = lg; o.lsu_rvalid = lrv;
    o.lsu_rdata = lrd; o.lsu_err = le; o.mem_req = mr; o.mem_we = mw; o.mem_be = mb;
    o.mem_addr = ma; o.mem_wdata = md;
    return o;
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    tbl.push_back(v);
  endtask

  task automatic drive(input in_t s);
    if_req_in = s.if_req;   if_addr_in = s.if_addr;
    lsu_req_in = s.lsu_req; lsu_we_in = s.lsu_we; lsu_be_in = s.lsu_be;
    lsu_addr_in = s.lsu_addr; lsu_wdata_in = s.lsu_wdata;
    mem_gnt_in = s.mem_gnt; mem_rvalid_in = s.mem_rvalid; mem_rdata_in = s.mem_rdata;
  endtask

  function automatic out_t sample();
    return mk_out(if_gnt_out, if_rvalid_out, if_rdata_out, lsu_gnt_out, lsu_rvalid_out,
                  lsu_rdata_out, lsu_err_out, mem_req_out, mem_we_out, mem_be_out,
                  mem_addr_out, mem_wdata_out);
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Legal when the enables cover 1, 2 or 4 contiguous bytes starting at a size-aligned offset.
  function automatic bit lsu_legal(logic [3:0] be, logic [31:0] addr);
    int size, off;
    size = $countones(be);
    off  = int'(addr[1:0]);
    if (!(size == 1 || size == 2 || size == 4)) return 1'b0;
    if ((off % size) != 0) return 1'b0;
    return be == 4'(((1 << size) - 1) << off);
  endfunction

  task automatic model_reset();
    m_owner = OWN_NONE; m_starve = 0; m_store = 1'b0;
  endtask

  task automatic model_eval(input in_t s, output out_t e);
    bit lsu_first;
    e = '0;
    n_owner = m_owner; n_store = m_store; n_starve = m_starve;
    if (m_owner == OWN_NONE) begin
      lsu_first = s.lsu_req && !(s.if_req && (m_starve == STARVE_MAX));
      if (lsu_first) begin
        if (!lsu_legal(s.lsu_be, s.lsu_addr)) begin
          e.lsu_gnt = 1'b1;
          n_owner   = OWN_ERR;
          if (s.if_req) n_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
        end else begin
          e.mem_req = 1'b1; e.mem_we = s.lsu_we; e.mem_be = s.lsu_be;
          e.mem_addr = s.lsu_addr; e.mem_wdata = s.lsu_wdata; e.lsu_gnt = s.mem_gnt;
          if (s.mem_gnt) begin
            n_owner = OWN_LSU;
            n_store = s.lsu_we;
            if (s.if_req) n_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
          end
        end
      end else if (s.if_req) begin
        e.mem_req = 1'b1; e.mem_be = 4'hF; e.mem_addr = s.if_addr; e.if_gnt = s.mem_gnt;
        if (s.mem_gnt) begin
          n_owner  = OWN_IF;
          n_starve = 0;
        end
      end
    end else if (m_owner == OWN_IF) begin
      if (s.mem_rvalid) begin
        e.if_rvalid = 1'b1; e.if_rdata = s.mem_rdata; n_owner = OWN_NONE;
      end
    end else if (m_owner == OWN_LSU) begin
      if (s.mem_rvalid) begin
        e.lsu_rvalid = 1'b1; e.lsu_rdata = m_store ? 32'h0 : s.mem_rdata; n_owner = OWN_NONE;
      end
    end else begin
      e.lsu_rvalid = 1'b1; e.lsu_err = 1'b1; n_owner = OWN_NONE;
    end
  endtask

  task automatic step(input in_t s, input string name, output out_t act);
    out_t exp;
    @(negedge clk_in);
    drive(s);
    #1;
    act = sample();
    model_eval(s, exp);
    check(name, act, exp);
    @(posedge clk_in);
    m_owner = n_owner; m_store = n_store; m_starve = n_starve;
  endtask

  initial begin
    out_t act;
    in_t  s;
    out_t z;
    logic [31:0] r;
    z = '0;

    be_pool = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'hF, 4'hF, 4'h6, 4'h0, 4'h5};

    // IF fetch at 0x40 with stray rvalid afterwards in IDLE.
    add(mk_in(1, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h40, 0));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), z);
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00500093), mk_out(0, 1, 32'h00500093, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF), z);
    // Misaligned word store, then ERR response ignoring a stray rvalid.
    add(mk_in(0, 0, 1, 1, 4'hF, 32'h102, 32'h11223344, 1, 0, 0), mk_out(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55), mk_out(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    // Upper-half store, then a word load.
    add(mk_in(0, 0, 1, 1, 4'hC, 32'h202, 32'hABCD0000, 1, 0, 0),
        mk_out(0, 0, 0, 1, 0, 0, 0, 1, 1, 4'hC, 32'h202, 32'hABCD0000));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678), mk_out(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 0, 1, 0, 4'hF, 32'h100, 0, 1, 0, 0), mk_out(0, 0, 0, 1, 0, 0, 0, 1, 0, 4'hF, 32'h100, 0));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D), mk_out(0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0));
    // Memory withholds grant for five cycles, grants on the sixth.
    for (int k = 0; k < 5; k++)
      add(mk_in(1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h80, 0));
    add(mk_in(1, 32'h80, 0, 0, 0, 0, 0, 1, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h80, 0));
    add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h13), mk_out(0, 1, 32'h13, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Both always requesting: LSU,LSU,LSU,IF repeats.
    for (int j = 0; j < 8; j++) begin
      if ((j % 4) == 3) begin
        add(mk_in(1, 32'h44, 1, 0, 4'hF, 32'h100, 0, 1, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h44, 0));
        add(mk_in(1, 32'h44, 1, 0, 4'hF, 32'h100, 0, 1, 1, 32'hA0 + j), mk_out(0, 1, 32'hA0 + j, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end else begin
        add(mk_in(1, 32'h44, 1, 0, 4'hF, 32'h100, 0, 1, 0, 0), mk_out(0, 0, 0, 1, 0, 0, 0, 1, 0, 4'hF, 32'h100, 0));
        add(mk_in(1, 32'h44, 1, 0, 4'hF, 32'h100, 0, 1, 1, 32'hA0 + j), mk_out(0, 0, 0, 0, 1, 32'hA0 + j, 0, 0, 0, 0, 0, 0));
      end
    end

    // Power-on reset with requests present: outputs must all read 0.
    drive(mk_in(1, 32'h40, 1, 0, 4'hF, 32'h100, 0, 1, 1, 32'h1));
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1 check("reset_outputs", sample(), z);
    model_reset();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].i, $sformatf("model[%0d]", k), act);
      check($sformatf("table[%0d]", k), act, tbl[k].o);
    end

    // Reset while a load is outstanding, then a late rvalid that must be dropped.
    step(mk_in(0, 0, 1, 0, 4'hF, 32'h300, 0, 1, 0, 0), "mid_reset_gnt", act);
    @(negedge clk_in);
    drive(mk_in(1, 32'h48, 1, 0, 4'hF, 32'h300, 0, 1, 0, 0));
    reset_n = 1'b0;
    #1 check("mid_reset_outputs", sample(), z);
    model_reset();
    @(posedge clk_in);
    @(negedge clk_in);
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset_n = 1'b1;
    step(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77), "late_rvalid", act);
    check("late_rvalid_zero", act, z);
    step(mk_in(1, 32'h4C, 0, 0, 0, 0, 0, 1, 0, 0), "post_reset_fetch", act);
    step(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99), "post_reset_rvalid", act);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      r = $urandom;
      s.if_req     = r[0] | r[1];
      s.if_addr    = {$urandom_range(32'hFFFF, 0) << 2};
      s.lsu_req    = r[2] | r[3];
      s.lsu_we     = r[4];
      s.lsu_be     = be_pool[$urandom_range(11, 0)];
      s.lsu_addr   = r[5] ? {$urandom_range(32'hFFFF, 0), 2'b00} : $urandom;
      s.lsu_wdata  = $urandom;
      s.mem_gnt    = (r[9:8] != 2'b00);
      s.mem_rvalid = r[10];
      s.mem_rdata  = $urandom;
      step(s, $sformatf("rand[%0d]", k), act);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
